// File: rtl/sha256_pkg.sv
// Shared types for the SHA-256 memory path: memory word width and the read response record.
package sha256_pkg;

   localparam int MEM_WORD_W = 32;

   typedef struct packed {
      logic [MEM_WORD_W-1:0] data;
      logic                  err;
   } MemResp;

endpackage

// File: rtl/sha_mem_responder_if.sv
// Hash-core read bus plus loader write port of the SHA memory responder.
// master = hash core / loader side, slave = responder side.
interface sha_mem_responder_if
   import sha256_pkg::*;
#(
   parameter int DEPTH = 64
);
   localparam int AW = $clog2(DEPTH);

   logic                  mem_addr_vld;
   logic [31:0]           mem_addr;
   logic                  mem_data_vld;
   logic [MEM_WORD_W-1:0] mem_data;
   logic                  mem_err;
   logic                  ld_vld;
   logic                  ld_rdy;
   logic [AW-1:0]         ld_addr;
   logic [MEM_WORD_W-1:0] ld_data;
   logic [31:0]           req_count;

   modport master (
      output mem_addr_vld, mem_addr, ld_vld, ld_addr, ld_data,
      input  mem_data_vld, mem_data, mem_err, ld_rdy, req_count
   );

   modport slave (
      input  mem_addr_vld, mem_addr, ld_vld, ld_addr, ld_data,
      output mem_data_vld, mem_data, mem_err, ld_rdy, req_count
   );

endinterface

// File: rtl/sha_mem_ram.sv
// Single-port synchronous RAM, DEPTH x MEM_WORD_W, one read-or-write port with registered read.
module sha_mem_ram
   import sha256_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  i_en,
   input  logic                  i_we,
   input  logic [AW-1:0]         i_addr,
   input  logic [MEM_WORD_W-1:0] i_wdata,
   output logic [MEM_WORD_W-1:0] o_rdata
);

   logic [MEM_WORD_W-1:0] r_mem [DEPTH];
   logic [MEM_WORD_W-1:0] r_rdata;

   // No reset on the array or read register so the tools map this onto block RAM.
   always_ff @(posedge clk) begin
      if (i_en) begin
         if (i_we) begin
            r_mem[i_addr] <= i_wdata;
         end else begin
            r_rdata <= r_mem[i_addr];
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/sha_mem_responder.sv
// Memory responder for the SHA-256 core: decodes byte addresses, flags illegal reads, serves a loader port.
// Optional macro SHA_MEM_OUTREG_EN adds an output register (latency 2 instead of 1).
module sha_mem_responder
   import sha256_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   sha_mem_responder_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   logic                  w_legal;
   logic [AW-1:0]         w_idx;
   logic [AW-1:0]         w_ram_addr;
   logic                  w_ram_en;
   logic                  w_ram_we;
   logic [MEM_WORD_W-1:0] w_ram_rdata;
   MemResp                w_resp;

   logic                  r_vld1;
   logic                  r_err1;
   logic [31:0]           r_req_count;
   MemResp                r_last;

   always_comb begin
      w_idx      = bus.mem_addr[AW+1:2];
      w_legal    = (bus.mem_addr[1:0] == 2'b00) && (bus.mem_addr[31:AW+2] == '0);
      // Reads own the port; loader writes are also held off while reset is asserted.
      w_ram_we   = bus.ld_vld && !bus.mem_addr_vld && rst_n;
      w_ram_en   = (bus.mem_addr_vld && w_legal) || w_ram_we;
      w_ram_addr = bus.mem_addr_vld ? w_idx : bus.ld_addr;
      w_resp.data = r_err1 ? '0 : w_ram_rdata;
      w_resp.err  = r_err1;
   end

   assign bus.ld_rdy    = ~bus.mem_addr_vld;
   assign bus.req_count = r_req_count;

   sha_mem_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .i_en    (w_ram_en),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (bus.ld_data),
      .o_rdata (w_ram_rdata)
   );

   // r_last keeps the most recent response so idle cycles hold data/err steady.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld1      <= 1'b0;
         r_err1      <= 1'b0;
         r_req_count <= '0;
         r_last      <= '0;
      end else begin
         r_vld1 <= bus.mem_addr_vld;
         if (bus.mem_addr_vld) begin
            r_err1      <= !w_legal;
            r_req_count <= r_req_count + 32'd1;
         end
         if (r_vld1) begin
            r_last <= w_resp;
         end
      end
   end

`ifdef SHA_MEM_OUTREG_EN
   logic r_vld2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld2 <= 1'b0;
      end else begin
         r_vld2 <= r_vld1;
      end
   end

   assign bus.mem_data_vld = r_vld2;
   assign bus.mem_data     = r_last.data;
   assign bus.mem_err      = r_last.err;
`else
   assign bus.mem_data_vld = r_vld1;
   assign bus.mem_data     = r_vld1 ? w_resp.data : r_last.data;
   assign bus.mem_err      = r_vld1 ? w_resp.err  : r_last.err;
`endif

endmodule

// File: tb/tb_sha_mem_responder.sv
// Self-checking bench for sha_mem_responder: randomized reads/loads against a word-array model.
module tb_sha_mem_responder;
   import sha256_pkg::*;

   localparam int DEPTH = 64;
   localparam int AW    = $clog2(DEPTH);
`ifdef SHA_MEM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic        err;
   } resp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] model_mem [DEPTH];
   logic [31:0] exp_count = '0;
   resp_t       exp_q[$];
   resp_t       obs_q[$];

   sha_mem_responder_if #(.DEPTH(DEPTH)) bus ();

   sha_mem_responder #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.mem_data_vld === 1'b1) obs_q.push_back('{cyc, bus.mem_data, bus.mem_err});
   end

   function automatic void push_expect(input logic [31:0] addr);
      resp_t e;
      e.cyc = cyc + LAT;
      if (addr % 4 == 0 && addr < 32'(DEPTH * 4)) begin
         e.data = model_mem[addr[AW+1:2]];
         e.err  = 1'b0;
      end else begin
         e.data = '0;
         e.err  = 1'b1;
      end
      exp_q.push_back(e);
      exp_count = exp_count + 32'd1;
   endfunction

   task automatic idle(input int n);
      bus.mem_addr_vld = 1'b0;
      bus.ld_vld       = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic load_word(input int idx, input logic [31:0] data);
      bus.mem_addr_vld = 1'b0;
      bus.ld_vld       = 1'b1;
      bus.ld_addr      = AW'(idx);
      bus.ld_data      = data;
      model_mem[idx]   = data;
      @(negedge clk);
      bus.ld_vld = 1'b0;
   endtask

   task automatic issue(input logic [31:0] addr);
      bus.mem_addr_vld = 1'b1;
      bus.mem_addr     = addr;
      push_expect(addr);
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.mem_addr_vld = 1'b1;
      bus.mem_addr     = '0;
      bus.ld_vld       = 1'b1;
      bus.ld_addr      = '0;
      bus.ld_data      = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.mem_data_vld !== 1'b0 || bus.mem_data !== 32'h0 || bus.mem_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got vld %b data %h err %b expected 0 0 0",
                  bus.mem_data_vld, bus.mem_data, bus.mem_err);
      end
      checks++;
      if (bus.req_count !== 32'h0) begin
         errors++;
         $display("FAIL reset_count: got %h expected 0", bus.req_count);
      end
      checks++;
      if (bus.ld_rdy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ldrdy_busy: got %b expected 0", bus.ld_rdy);
      end
      bus.mem_addr_vld = 1'b0;
      #1;
      checks++;
      if (bus.ld_rdy !== 1'b1) begin
         errors++;
         $display("FAIL reset_ldrdy_idle: got %b expected 1", bus.ld_rdy);
      end
      bus.ld_vld = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_load_read();
      resp_t o, e;
      load_word(0, 32'h11111111);
      load_word(1, 32'h22222222);
      load_word(2, 32'h33333333);
      load_word(3, 32'h44444444);
      for (int i = 0; i < 4; i++) issue(32'(i * 4));
      idle(LAT + 2);
      #1;
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL load_read_count: got %0d responses expected %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.cyc !== e.cyc || o.data !== e.data || o.err !== e.err) begin
            errors++;
            $display("FAIL load_read_resp: got cyc %0d data %h err %b expected cyc %0d data %h err %b",
                     o.cyc, o.data, o.err, e.cyc, e.data, e.err);
         end
      end
      obs_q.delete();
      exp_q.delete();
      checks++;
      if (bus.mem_data_vld !== 1'b0 || bus.mem_data !== 32'h44444444 || bus.mem_err !== 1'b0) begin
         errors++;
         $display("FAIL load_read_hold: got vld %b data %h err %b expected 0 44444444 0",
                  bus.mem_data_vld, bus.mem_data, bus.mem_err);
      end
   endtask

   task automatic test_illegal();
      resp_t o, e;
      issue(32'h2);
      issue(32'(DEPTH * 4));
      idle(LAT + 2);
      #1;
      checks++;
      if (obs_q.size() != 2 || exp_q.size() != 2) begin
         errors++;
         $display("FAIL illegal_count: got %0d responses expected 2", obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.cyc !== e.cyc || o.data !== 32'h0 || o.err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_resp: got cyc %0d data %h err %b expected cyc %0d data 00000000 err 1",
                     o.cyc, o.data, o.err, e.cyc);
         end
      end
      obs_q.delete();
      exp_q.delete();
      checks++;
      if (bus.req_count !== exp_count) begin
         errors++;
         $display("FAIL illegal_req_count: got %h expected %h", bus.req_count, exp_count);
      end
      checks++;
      if (bus.mem_data !== 32'h0 || bus.mem_err !== 1'b1) begin
         errors++;
         $display("FAIL illegal_hold: got data %h err %b expected 0 1", bus.mem_data, bus.mem_err);
      end
   endtask

   task automatic test_random();
      resp_t       o, e;
      bit          rv, lv;
      int          idx;
      logic [31:0] addr;
      for (int i = 0; i < DEPTH; i++) load_word(i, $urandom);
      for (int n = 0; n < 200; n++) begin
         rv  = 1'($urandom_range(0, 1));
         lv  = 1'($urandom_range(0, 1));
         idx = $urandom_range(0, DEPTH - 1);
         case ($urandom_range(0, 3))
            0, 1:    addr = 32'(idx * 4);
            2:       addr = 32'(idx * 4 + $urandom_range(1, 3));
            default: begin
               addr = $urandom;
               if (addr < 32'(DEPTH * 4)) addr = addr + 32'(DEPTH * 4);
            end
         endcase
         bus.ld_vld       = lv;
         bus.ld_addr      = AW'($urandom_range(0, DEPTH - 1));
         bus.ld_data      = $urandom;
         bus.mem_addr_vld = rv;
         bus.mem_addr     = addr;
         if (rv) push_expect(addr);
         #1;
         checks++;
         if (bus.ld_rdy !== !rv) begin
            errors++;
            $display("FAIL random_ldrdy: got %b expected %b", bus.ld_rdy, !rv);
         end
         if (lv && !rv) model_mem[bus.ld_addr] = bus.ld_data;
         @(negedge clk);
      end
      idle(LAT + 2);
      #1;
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL random_count: got %0d responses expected %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.cyc !== e.cyc || o.data !== e.data || o.err !== e.err) begin
            errors++;
            $display("FAIL random_resp: got cyc %0d data %h err %b expected cyc %0d data %h err %b",
                     o.cyc, o.data, o.err, e.cyc, e.data, e.err);
         end
      end
      obs_q.delete();
      exp_q.delete();
      checks++;
      if (bus.req_count !== exp_count) begin
         errors++;
         $display("FAIL random_req_count: got %h expected %h", bus.req_count, exp_count);
      end
   endtask

   task automatic test_contention();
      resp_t       o, e;
      logic [31:0] d;
      d = $urandom;
      bus.ld_vld  = 1'b1;
      bus.ld_addr = AW'(2);
      bus.ld_data = d;
      for (int i = 0; i < 3; i++) begin
         bus.mem_addr_vld = 1'b1;
         bus.mem_addr     = 32'(i * 4);
         push_expect(32'(i * 4));
         #1;
         checks++;
         if (bus.ld_rdy !== 1'b0) begin
            errors++;
            $display("FAIL contention_ldrdy_busy: cycle %0d got %b expected 0", i, bus.ld_rdy);
         end
         @(negedge clk);
      end
      bus.mem_addr_vld = 1'b0;
      #1;
      checks++;
      if (bus.ld_rdy !== 1'b1) begin
         errors++;
         $display("FAIL contention_ldrdy_free: got %b expected 1", bus.ld_rdy);
      end
      model_mem[2] = d;
      @(negedge clk);
      bus.ld_vld = 1'b0;
      issue(32'h8);
      idle(LAT + 2);
      #1;
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL contention_count: got %0d responses expected %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.cyc !== e.cyc || o.data !== e.data || o.err !== e.err) begin
            errors++;
            $display("FAIL contention_resp: got cyc %0d data %h err %b expected cyc %0d data %h err %b",
                     o.cyc, o.data, o.err, e.cyc, e.data, e.err);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset_midflight();
      resp_t o, e;
      bus.mem_addr_vld = 1'b1;
      bus.mem_addr     = 32'h4;
      @(posedge clk);
      #2;
      rst_n            = 1'b0;
      bus.mem_addr_vld = 1'b0;
      bus.ld_vld       = 1'b1;
      bus.ld_addr      = AW'(1);
      bus.ld_data      = 32'hDEADBEEF;
      exp_count        = '0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.mem_data_vld !== 1'b0 || bus.mem_data !== 32'h0 || bus.mem_err !== 1'b0 ||
          bus.req_count !== 32'h0) begin
         errors++;
         $display("FAIL midflight_reset_state: got vld %b data %h err %b count %h expected 0 0 0 0",
                  bus.mem_data_vld, bus.mem_data, bus.mem_err, bus.req_count);
      end
      bus.ld_vld = 1'b0;
      rst_n      = 1'b1;
      idle(LAT + 3);
      #1;
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL midflight_dropped: got %0d responses expected 0", obs_q.size());
      end
      obs_q.delete();
      checks++;
      if (bus.req_count !== exp_count) begin
         errors++;
         $display("FAIL midflight_req_count: got %h expected %h", bus.req_count, exp_count);
      end
      issue(32'h0);
      issue(32'h4);
      idle(LAT + 2);
      #1;
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL midflight_count: got %0d responses expected %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.cyc !== e.cyc || o.data !== e.data || o.err !== e.err) begin
            errors++;
            $display("FAIL midflight_resp: got cyc %0d data %h err %b expected cyc %0d data %h err %b",
                     o.cyc, o.data, o.err, e.cyc, e.data, e.err);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_wrap();
      force dut.r_req_count = 32'hFFFFFFFE;
      @(negedge clk);
      release dut.r_req_count;
      exp_count = 32'hFFFFFFFE;
      @(negedge clk);
      issue(32'h0);
      bus.mem_addr_vld = 1'b0;
      #1;
      checks++;
      if (bus.req_count !== exp_count) begin
         errors++;
         $display("FAIL wrap_max: got %h expected %h", bus.req_count, exp_count);
      end
      issue(32'h3);
      bus.mem_addr_vld = 1'b0;
      #1;
      checks++;
      if (bus.req_count !== exp_count || exp_count !== 32'h0) begin
         errors++;
         $display("FAIL wrap_zero: got %h expected %h", bus.req_count, exp_count);
      end
      idle(LAT + 2);
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_load_read();
      test_illegal();
      test_random();
      test_contention();
      test_reset_midflight();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sha_mem_responder.md
SHA_MEM_RESPONDER -- requirements
Module: sha_mem_responder

Interface
REQ-001 Parameter DEPTH, default 64, meaning number of 32-bit words stored; power of two, 4..4096.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 mem_addr_vld  input  1  read request strobe from hash core; no ready, accepted every cycle.
REQ-005 mem_addr  input  32  byte address of requested word.
REQ-006 mem_data_vld  output  1  read response strobe.
REQ-007 mem_data  output  32  read response word.
REQ-008 mem_err  output  1  response error flag, valid with mem_data_vld.
REQ-009 ld_vld  input  1  loader write request.
REQ-010 ld_rdy  output  1  loader write accepted when high with ld_vld.
REQ-011 ld_addr  input  $clog2(DEPTH)  loader word index.
REQ-012 ld_data  input  32  loader write word.
REQ-013 req_count  output  32  count of read requests accepted since reset.

Function
REQ-014 Word index = mem_addr[$clog2(DEPTH)+1:2]; a request is legal when mem_addr[1:0]==0 and mem_addr[31:$clog2(DEPTH)+2]==0.
REQ-015 Legal request: response carries stored word, mem_err=0.
REQ-016 Illegal request (misaligned or out of range): response carries 32'h0, mem_err=1; storage untouched.
REQ-017 Exactly one response per accepted request, in request order; back-to-back requests every cycle yield back-to-back responses.
REQ-018 mem_data_vld=0 cycles: mem_data and mem_err hold their last values.
REQ-019 Storage is single-port; reads take priority: ld_rdy = ~mem_addr_vld, combinational.
REQ-020 Write occurs on the edge where ld_vld && ld_rdy; ld_vld with ld_rdy=0 has no effect, loader holds and retries.
REQ-021 Read of a word written in an earlier cycle returns the new value; read and write never coincide (REQ-019).
REQ-022 req_count increments by 1 per cycle with mem_addr_vld=1 (legal or illegal); wraps 32'hFFFFFFFF -> 0.
REQ-023 Storage contents are not initialised; reads before any load return undefined data with mem_err=0.

Reset
REQ-024 rst_n low asynchronously forces mem_data_vld=0, mem_data=0, mem_err=0, req_count=0, pipeline valid bits=0.
REQ-025 Requests in flight when reset asserts are dropped; no response appears after reset deasserts.
REQ-026 Storage contents survive reset.
REQ-027 ld_rdy follows REQ-019 during reset; writes are blocked while rst_n=0.

Configuration
REQ-028 Macro SHA_MEM_OUTREG_EN defined: extra output register stage, response latency 2 cycles after request.
REQ-029 SHA_MEM_OUTREG_EN undefined: response latency 1 cycle after request (matches the dummy single-cycle memory).
REQ-030 Both builds obey REQ-015..REQ-027 identically apart from latency.

Structure
REQ-031 Shared sha256_pkg holds MEM_WORD_W=32 and the MemResp struct {data, err}; the module uses them.
REQ-032 One sub-module sha_mem_ram: single-port synchronous RAM, DEPTH x 32, one read-or-write port, inferable as block RAM.
REQ-033 Address decode, legality check, valid pipeline, counter and loader handshake stay in sha_mem_responder.

Verification
REQ-034 Load words 0..3 = 32'h11111111, 22222222, 33333333, 44444444; read addrs 0x0,0x4,0x8,0xC on consecutive cycles -> four consecutive responses in that order, mem_err=0, at latency 1 (2 with macro).
REQ-035 Read mem_addr=0x2 and mem_addr=DEPTH*4 -> mem_data=0, mem_err=1 both; req_count advances by 2.
REQ-036 Hold ld_vld with mem_addr_vld high 3 cycles -> ld_rdy=0 for 3 cycles, write lands the cycle after mem_addr_vld drops; subsequent read returns ld_data.
REQ-037 Issue request, assert rst_n low same cycle as it would respond -> no mem_data_vld after release; req_count=0; earlier loaded word still readable.
REQ-038 Preload req_count near wrap via 2^32-1 requests (forced in sim) then one more -> req_count=0.
REQ-039 Connect to sha256 core with ctx length 256 -> core completes with digest matching software model over loaded data.
